// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding and counter-width helper for the x_in debouncer
package debounce_pkg;

    typedef logic [1:0] db_state_t;

    localparam db_state_t STABLE_LO = 2'b00;
    localparam db_state_t WAIT_HI   = 2'b01;
    localparam db_state_t STABLE_HI = 2'b11;
    localparam db_state_t WAIT_LO   = 2'b10;

    // Hold counter must be able to represent DEBOUNCE_CYCLES itself.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - reset-clearable synchroniser shift register for asynchronous inputs
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge clk) begin
        if (rst) begin
            stages <= '0;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/x_in_debounce.sv
// rtl/x_in_debounce.sv - synchroniser plus 4-state debounce FSM producing a clean x_in level
// Optional edge pulses on x_rise/x_fall when EDGE_PULSE_EN is defined; tied low otherwise.
module x_in_debounce
    import debounce_pkg::*;
#(
    parameter  int SYNC_STAGES     = 2,
    parameter  int DEBOUNCE_CYCLES = 16,
    localparam int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic x_level,
    output logic x_rise,
    output logic x_fall,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             btn_s;
    db_state_t        state;
    db_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (btn_raw),
        .q  (btn_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= STABLE_LO;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Any reversion of btn_s during a wait returns to the stable state and restarts timing.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            STABLE_LO: begin
                if (btn_s) begin
                    state_nxt = WAIT_HI;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt   = '0;
                end
            end
            WAIT_HI: begin
                if (!btn_s) begin
                    state_nxt = STABLE_LO;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = STABLE_HI;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!btn_s) begin
                    state_nxt = WAIT_LO;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt   = '0;
                end
            end
            WAIT_LO: begin
                if (btn_s) begin
                    state_nxt = STABLE_HI;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = STABLE_LO;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = STABLE_LO;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        x_level = (state == STABLE_HI) || (state == WAIT_LO);
        busy    = (state == WAIT_HI) || (state == WAIT_LO);
    end

`ifdef EDGE_PULSE_EN
    // Delayed copy of x_level; cleared on reset so reset never produces a pulse.
    logic x_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            x_prev <= 1'b0;
        end else begin
            x_prev <= x_level;
        end
    end

    assign x_rise = x_level & ~x_prev;
    assign x_fall = ~x_level & x_prev;
`else
    assign x_rise = 1'b0;
    assign x_fall = 1'b0;
`endif

endmodule
